// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead FIFO into a framed valid/ready stream via a 2-entry buffer
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_re,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [31:0]           words_out,
  output logic [LEN_WIDTH-1:0]  pkts_out
);
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] d1;
  logic                  l1;
  logic [LEN_WIDTH-1:0]  pcnt, cur_len, len_eff;
  logic                  tag, ret;
  assign out_valid = cnt != 2'd0;
  assign ret       = out_valid & out_ready;
  assign fifo_re   = ~reset & enable & ~fifo_empty & (cnt != 2'd2);
  // First pop of a packet frames against the live pkt_len, later pops against the latched length
  always_comb begin
    len_eff = pcnt == '0 ? pkt_len : cur_len;
    tag     = len_eff != '0 && pcnt == len_eff - LEN_WIDTH'(1);
  end
  // Packet framing state advances on every pop; unframed streams keep pcnt at 0
  always_ff @(posedge rclk) begin
    if (reset) begin
      pcnt    <= '0;
      cur_len <= '0;
    end else if (fifo_re) begin
      if (pcnt == '0) cur_len <= pkt_len;
      pcnt <= (tag || len_eff == '0) ? '0 : pcnt + LEN_WIDTH'(1);
    end
  end
  // Two-entry buffer: head lives in out_data/out_last, a push lands in head when it is (or becomes) free
  always_ff @(posedge rclk) begin
    if (reset) begin
      cnt       <= 2'd0;
      out_data  <= '0;
      out_last  <= 1'b0;
      d1        <= '0;
      l1        <= 1'b0;
      words_out <= '0;
      pkts_out  <= '0;
    end else begin
      if (ret) begin
        out_data  <= d1;
        out_last  <= l1;
        words_out <= words_out + 32'd1;
        if (out_last) pkts_out <= pkts_out + LEN_WIDTH'(1);
      end
      if (fifo_re) begin
        if (cnt == 2'd0 || (cnt == 2'd1 && ret)) begin
          out_data <= fifo_rdata;
          out_last <= tag;
        end else begin
          d1 <= fifo_rdata;
          l1 <= tag;
        end
      end
      cnt <= cnt + {1'b0, fifo_re} - {1'b0, ret};
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench with a queue-based FIFO model and packet framing reference
module tb_fifo_stream_reader;
  typedef struct {logic [7:0] d; logic l;} ent_t;
  logic        rclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pkt_len = 16'd0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_re, out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [31:0] words_out;
  logic [15:0] pkts_out;
  logic        stall = 1'b0;
  logic [7:0]  fq[$];
  ent_t        exp_q[$];
  int          nchk = 0, nerr = 0;
  int          pops = 0, pos = 0, len = 0;
  int          wm = 0, pm = 0;
  bit          pushed_now = 0;

  fifo_stream_reader dut (
    .rclk(rclk), .reset(reset), .enable(enable), .pkt_len(pkt_len),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_re(fifo_re),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .words_out(words_out), .pkts_out(pkts_out)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // FIFO model outputs settle after pops (+1) and new stimulus (+2)
  always begin
    @(posedge rclk);
    #3;
    fifo_empty = stall || fq.size() == 0;
    fifo_rdata = fq.size() != 0 ? fq[0] : 8'($urandom);
  end

  // Feeder: predicts pops, frames each popped word and pushes it onto the scoreboard
  always begin
    bit pend;
    bit last;
    @(negedge rclk);
    pushed_now = 0;
    pend = 0;
    if (reset) begin
      chk("fifo_re_in_reset", {31'd0, fifo_re}, 32'd0);
      exp_q.delete();
      pos = 0;
    end else begin
      chk("fifo_re", {31'd0, fifo_re}, {31'd0, enable && !fifo_empty && exp_q.size() < 2});
      if (fifo_re && !fifo_empty) begin
        if (pos == 0) len = int'(pkt_len);
        last = len != 0 && pos + 1 == len;
        pos = (len == 0 || last) ? 0 : pos + 1;
        exp_q.push_back('{d: fq[0], l: last});
        pushed_now = 1;
        pend = 1;
        pops++;
      end
    end
    @(posedge rclk);
    #1;
    if (pend) void'(fq.pop_front());
  end

  // Monitor: compares the presented word and counters against the scoreboard head
  always begin
    ent_t e;
    int   older;
    @(negedge rclk);
    #1;
    if (reset) begin
      wm = 0;
      pm = 0;
    end else begin
      older = exp_q.size() - (pushed_now ? 1 : 0);
      chk("out_valid", {31'd0, out_valid}, {31'd0, older != 0});
      if (out_valid && older != 0) begin
        chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].d});
        chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].l});
      end
      chk("words_out", words_out, wm);
      chk("pkts_out", {16'd0, pkts_out}, pm);
      if (out_valid && out_ready && older != 0) begin
        e = exp_q.pop_front();
        wm++;
        if (e.l) pm++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && n < 300) begin
      step(1);
      n++;
    end
    chk("drain_bound", {31'd0, n < 300}, 32'd1);
  endtask

  initial begin
    int p0;
    step(3);
    reset = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    pkt_len = 16'd0;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    drain();
    step(2);
    chk("basic_words", words_out, 32'd3);
    chk("basic_pkts", {16'd0, pkts_out}, 32'd0);
    pkt_len = 16'd4;
    for (int i = 1; i <= 9; i++) fq.push_back(8'(8'h40 + i));
    drain();
    pkt_len = 16'd2;
    for (int i = 10; i <= 12; i++) fq.push_back(8'(8'h40 + i));
    drain();
    step(2);
    chk("frame_pkts", {16'd0, pkts_out}, 32'd3);
    chk("frame_words", words_out, 32'd15);
    pkt_len = 16'd0;
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 5; i++) fq.push_back(8'(8'h60 + i));
    step(8);
    chk("bp_pops", pops - p0, 32'd2);
    chk("bp_hold_data", {24'd0, out_data}, 32'h61);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drain();
    enable = 1'b0;
    pkt_len = 16'd3;
    p0 = pops;
    for (int i = 1; i <= 3; i++) fq.push_back(8'(8'h70 + i));
    step(4);
    chk("en_no_pops", pops - p0, 32'd0);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    drain();
    step(2);
    chk("en_pkts", {16'd0, pkts_out}, 32'd4);
    pkt_len = 16'd4;
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) fq.push_back(8'(8'h80 + i));
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_words", words_out, 32'd0);
    chk("rst_pkts", {16'd0, pkts_out}, 32'd0);
    out_ready = 1'b1;
    drain();
    step(2);
    chk("rst_pkt_done", {16'd0, pkts_out}, 32'd1);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 16) fq.push_back(8'($urandom));
      stall = $urandom_range(0, 3) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      enable = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 15) == 0) pkt_len = 16'($urandom_range(0, 5));
      step(1);
    end
    stall = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    drain();
    step(2);
    chk("rand_pkts", {16'd0, pkts_out}, pm);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
